// File: rtl/timing_mgr_pkg.sv
// Shared types and constants for the sensor timing sequencer.
// Sensor indices must track the sensor_e ordering used by the driver.
package timing_mgr_pkg;

    localparam int unsigned N_SENSORS_DEF = 10;
    localparam int unsigned TIME_W_DEF    = 16;
    localparam int unsigned RATIO_W_DEF   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } state_e;

    localparam int unsigned ADC     = 0;
    localparam int unsigned ENCODER = 1;
    localparam int unsigned AMDS0   = 2;
    localparam int unsigned AMDS1   = 3;
    localparam int unsigned AMDS2   = 4;
    localparam int unsigned AMDS3   = 5;
    localparam int unsigned EDDY0   = 6;
    localparam int unsigned EDDY1   = 7;
    localparam int unsigned EDDY2   = 8;
    localparam int unsigned EDDY3   = 9;

endpackage

// File: rtl/timing_capture_ch.sv
// One sensor channel: done edge detect, latency capture and timeout flag.
// Optional max-latency tracking is built when TIMING_MGR_MAXTIME_EN is defined.
module timing_capture_ch
    import timing_mgr_pkg::*;
#(
    parameter int unsigned TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acq,
    input  logic              mask_bit,
    input  logic              done,
    input  logic [TIME_W-1:0] count_time,
    input  logic              timeout_hit,
`ifdef TIMING_MGR_MAXTIME_EN
    input  logic              clr_stats,
    output logic [TIME_W-1:0] max_time,
`endif
    output logic              cap_evt,
    output logic              captured,
    output logic [TIME_W-1:0] sensor_time,
    output logic              timed_out
);

    logic done_q;

    assign cap_evt = acq & mask_bit & ~captured & done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b0;
            captured    <= 1'b0;
            sensor_time <= '0;
            timed_out   <= 1'b0;
        end else begin
            done_q <= done;
            if (start) begin
                captured  <= 1'b0;
                timed_out <= 1'b0;
            end else begin
                if (cap_evt) begin
                    captured    <= 1'b1;
                    sensor_time <= count_time;
                end
                // A capture in the timeout cycle still counts as on time.
                if (timeout_hit && mask_bit && !captured && !cap_evt)
                    timed_out <= 1'b1;
            end
        end
    end

`ifdef TIMING_MGR_MAXTIME_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            max_time <= '0;
        end else if (clr_stats) begin
            max_time <= cap_evt ? count_time : '0;
        end else if (cap_evt && (count_time > max_time)) begin
            max_time <= count_time;
        end
    end
`endif

endmodule

// File: rtl/sensor_timing_sequencer.sv
// Sensor acquisition trigger sequencer with per-channel latency capture,
// timeout and overrun counting. Optional feature macro: TIMING_MGR_MAXTIME_EN.
module sensor_timing_sequencer
    import timing_mgr_pkg::*;
#(
    parameter int unsigned N_SENSORS = N_SENSORS_DEF,
    parameter int unsigned TIME_W    = TIME_W_DEF,
    parameter int unsigned RATIO_W   = RATIO_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        auto_mode,
    input  logic                        manual_trig_req,
    input  logic                        event_qualifier,
    input  logic [RATIO_W-1:0]          user_ratio,
    input  logic [N_SENSORS-1:0]        en_bits,
    input  logic [N_SENSORS-1:0]        done,
    input  logic                        sched_src_mode,
    input  logic                        isr_ack,
    input  logic [TIME_W-1:0]           timeout_limit,
`ifdef TIMING_MGR_MAXTIME_EN
    input  logic                        clr_stats,
    output logic [N_SENSORS*TIME_W-1:0] max_time,
`endif
    output logic [N_SENSORS-1:0]        en_out,
    output logic                        trigger,
    output logic                        busy,
    output logic                        sched_isr,
    output logic [TIME_W-1:0]           count_time,
    output logic [N_SENSORS*TIME_W-1:0] sensor_time,
    output logic [N_SENSORS-1:0]        timed_out,
    output logic [15:0]                 overrun_cnt
);

    state_e               state, state_nx;
    logic [RATIO_W-1:0]   ev_cnt;
    logic                 pending;
    logic [N_SENSORS-1:0] mask;
    logic [N_SENSORS-1:0] cap_evt;
    logic [N_SENSORS-1:0] captured;
    logic                 ratio_hit;
    logic                 trig_cond;
    logic                 timeout_hit;
    logic                 all_done;
    logic                 take;
    logic                 acq_end;
    logic                 overrun_evt;
    logic                 isr_set;

    assign ratio_hit   = event_qualifier && (ev_cnt == user_ratio);
    assign trig_cond   = (auto_mode & ratio_hit) | (pending & event_qualifier);
    assign timeout_hit = (state == ACQ) && (timeout_limit != '0) && (count_time == timeout_limit);
    assign all_done    = &(~mask | captured | cap_evt);
    assign isr_set     = (sched_src_mode && (en_bits != '0)) ? acq_end : ratio_hit;
    assign en_out      = en_bits;
    assign busy        = (state == ACQ);

    always_comb begin
        state_nx    = state;
        take        = 1'b0;
        acq_end     = 1'b0;
        overrun_evt = 1'b0;
        case (state)
            IDLE: begin
                if (trig_cond && (en_bits != '0)) begin
                    take     = 1'b1;
                    state_nx = ACQ;
                end
            end
            ACQ: begin
                overrun_evt = trig_cond;
                if (all_done || timeout_hit) begin
                    acq_end  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_cnt      <= '0;
            pending     <= 1'b0;
            mask        <= '0;
            trigger     <= 1'b0;
            count_time  <= '0;
            overrun_cnt <= '0;
            sched_isr   <= 1'b0;
        end else begin
            if (event_qualifier)
                ev_cnt <= ratio_hit ? '0 : ev_cnt + 1'b1;
            // A request landing in the issuing cycle survives for the next trigger.
            pending <= manual_trig_req | (pending & ~take);
            trigger <= take;
            if (take) begin
                mask       <= en_bits;
                count_time <= '0;
            end else if (count_time != '1) begin
                count_time <= count_time + 1'b1;
            end
`ifdef TIMING_MGR_MAXTIME_EN
            if (clr_stats)
                overrun_cnt <= '0;
            else
`endif
            if (overrun_evt && (overrun_cnt != 16'hFFFF))
                overrun_cnt <= overrun_cnt + 16'd1;
            if (isr_set)
                sched_isr <= 1'b1;
            else if (isr_ack)
                sched_isr <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_ch
        timing_capture_ch #(
            .TIME_W(TIME_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .start       (take),
            .acq         (busy),
            .mask_bit    (mask[i]),
            .done        (done[i]),
            .count_time  (count_time),
            .timeout_hit (timeout_hit),
`ifdef TIMING_MGR_MAXTIME_EN
            .clr_stats   (clr_stats),
            .max_time    (max_time[i*TIME_W +: TIME_W]),
`endif
            .cap_evt     (cap_evt[i]),
            .captured    (captured[i]),
            .sensor_time (sensor_time[i*TIME_W +: TIME_W]),
            .timed_out   (timed_out[i])
        );
    end

endmodule

// File: tb/tb_sensor_timing_sequencer.sv
// Directed and randomized checks of sensor_timing_sequencer against an
// acquisition-level model (per-channel done delays -> captures, end time, flags).
module tb_sensor_timing_sequencer;
    import timing_mgr_pkg::*;

    localparam int N  = 10;
    localparam int TW = 16;
    localparam int RW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            auto_mode = 1'b0;
    logic            manual_trig_req = 1'b0;
    logic            event_qualifier = 1'b0;
    logic [RW-1:0]   user_ratio = '0;
    logic [N-1:0]    en_bits = '0;
    logic [N-1:0]    done = '0;
    logic            sched_src_mode = 1'b0;
    logic            isr_ack = 1'b0;
    logic [TW-1:0]   timeout_limit = '0;
    logic [N-1:0]    en_out;
    logic            trigger;
    logic            busy;
    logic            sched_isr;
    logic [TW-1:0]   count_time;
    logic [N*TW-1:0] sensor_time;
    logic [N-1:0]    timed_out;
    logic [15:0]     overrun_cnt;
`ifdef TIMING_MGR_MAXTIME_EN
    logic            clr_stats = 1'b0;
    logic [N*TW-1:0] max_time;
`endif

    always #5 clk = ~clk;

    sensor_timing_sequencer #(
        .N_SENSORS(N),
        .TIME_W   (TW),
        .RATIO_W  (RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .auto_mode       (auto_mode),
        .manual_trig_req (manual_trig_req),
        .event_qualifier (event_qualifier),
        .user_ratio      (user_ratio),
        .en_bits         (en_bits),
        .done            (done),
        .sched_src_mode  (sched_src_mode),
        .isr_ack         (isr_ack),
        .timeout_limit   (timeout_limit),
`ifdef TIMING_MGR_MAXTIME_EN
        .clr_stats       (clr_stats),
        .max_time        (max_time),
`endif
        .en_out          (en_out),
        .trigger         (trigger),
        .busy            (busy),
        .sched_isr       (sched_isr),
        .count_time      (count_time),
        .sensor_time     (sensor_time),
        .timed_out       (timed_out),
        .overrun_cnt     (overrun_cnt)
    );

    int total = 0;
    int bad   = 0;
    int dly[N];
    int exp_st[N];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*TW-1:0] st_bus();
        logic [N*TW-1:0] b;
        logic [TW-1:0]   v;
        b = '0;
        for (int i = 0; i < N; i++) begin
            v = exp_st[i][TW-1:0];
            b[i*TW +: TW] = v;
        end
        return b;
    endfunction

    task automatic clear_dly();
        for (int i = 0; i < N; i++) dly[i] = -1;
    endtask

    task automatic do_reset();
        auto_mode = 1'b0; manual_trig_req = 1'b0; event_qualifier = 1'b0;
        done = '0; isr_ack = 1'b0; timeout_limit = '0;
        rst = 1'b1;
        step();
        chk("rst_trigger", trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_isr", sched_isr, 0);
        chk("rst_count", count_time, 0);
        chk("rst_sensor_time", sensor_time, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_overrun", overrun_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) exp_st[i] = 0;
    endtask

    task automatic start_manual();
        manual_trig_req = 1'b1;
        step();
        manual_trig_req = 1'b0;
        event_qualifier = 1'b1;
        step();
        event_qualifier = 1'b0;
        chk("start_trigger", trigger, 1);
        chk("start_count", count_time, 0);
        chk("start_busy", busy, 1);
    endtask

    // Acquisition model: channel captured iff its done delay lands no later than
    // the timeout; acquisition ends at the last capture or at the timeout count.
    task automatic run_acq(input logic [N-1:0] mask, input int lim, input logic [N-1:0] en_after);
        int           fin;
        bit           all_cap;
        logic [N-1:0] to;
        fin = 0; all_cap = 1'b1; to = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (dly[i] > 0 && (lim == 0 || dly[i] <= lim)) begin
                    if (dly[i] > fin) fin = dly[i];
                end else begin
                    all_cap = 1'b0;
                    to[i] = 1'b1;
                end
            end
        end
        if (!all_cap) fin = lim;
        for (int i = 0; i < N; i++)
            if (mask[i] && !to[i]) exp_st[i] = dly[i];
        en_bits = en_after;
        for (int k = 0; k <= fin; k++) begin
            for (int i = 0; i < N; i++)
                if (dly[i] == k) done[i] = 1'b1;
            if (k == fin) chk("busy_last_cycle", busy, 1);
            step();
        end
        chk("acq_busy_end", busy, 0);
        chk("acq_isr", sched_isr, 1);
        chk("acq_timed_out", timed_out, to);
        chk("acq_sensor_time", sensor_time, st_bus());
        chk("acq_count", count_time, fin + 1);
        chk("acq_en_out", en_out, en_after);
        isr_ack = 1'b1;
        step();
        isr_ack = 1'b0;
        chk("isr_ack_clear", sched_isr, 0);
        done = '0;
        step();
    endtask

    initial begin
        bit           seen;
        int           tcount;
        int           lim;
        bit           any_none;
        logic [N-1:0] m;
        logic [N-1:0] ea;

        clear_dly();
        do_reset();

        // Ratio timing: every third carrier event triggers, ADC done at 40.
        auto_mode = 1'b1; user_ratio = 2; en_bits = 10'h001; sched_src_mode = 1'b1;
        for (int ev = 1; ev <= 6; ev++) begin
            event_qualifier = 1'b1;
            step();
            event_qualifier = 1'b0;
            chk("ratio_trigger", trigger, (ev % 3 == 0));
            if (ev % 3 == 0) begin
                chk("ratio_count0", count_time, 0);
                clear_dly();
                dly[ADC] = 40;
                run_acq(10'h001, 0, 10'h001);
            end else begin
                chk("ratio_no_isr", sched_isr, 0);
            end
            repeat (50) step();
        end

        // Multi-channel capture.
        do_reset();
        sched_src_mode = 1'b1; en_bits = 10'h005;
        start_manual();
        clear_dly(); dly[2] = 25; dly[0] = 60;
        run_acq(10'h005, 0, 10'h005);

        // Timeout with one channel silent.
        en_bits = 10'h003; timeout_limit = 50;
        start_manual();
        clear_dly(); dly[0] = 10;
        run_acq(10'h003, 50, 10'h003);
        timeout_limit = 0;

        // Ratio hit with no enabled sensors: no trigger, ISR from ratio hit.
        do_reset();
        auto_mode = 1'b1; user_ratio = 0; en_bits = '0; sched_src_mode = 1'b1;
        event_qualifier = 1'b1;
        step();
        event_qualifier = 1'b0;
        chk("noen_trigger", trigger, 0);
        chk("noen_busy", busy, 0);
        chk("noen_isr", sched_isr, 1);
        isr_ack = 1'b1; step(); isr_ack = 1'b0;

        // Overrun: events every 20 cycles, ADC done at count 45.
        do_reset();
        auto_mode = 1'b1; user_ratio = 0; en_bits = 10'h001; sched_src_mode = 1'b1;
        tcount = 0;
        for (int c = 0; c <= 70; c++) begin
            event_qualifier = (c % 20 == 0) && (c <= 60);
            done[0] = (c == 46);
            step();
            if (trigger) tcount++;
        end
        event_qualifier = 1'b0; done = '0;
        exp_st[0] = 45;
        chk("ovr_triggers", tcount, 2);
        chk("ovr_count", overrun_cnt, 2);
        chk("ovr_sensor_time", sensor_time, st_bus());
        chk("ovr_busy", busy, 1);

        // Reset in the middle of the second acquisition.
        repeat (2) step();
        chk("mid_count", count_time, 12);
        do_reset();

        // Manual mode: request waits for the next carrier event.
        auto_mode = 1'b0; en_bits = 10'h001; sched_src_mode = 1'b1; user_ratio = 3;
        manual_trig_req = 1'b1; step(); manual_trig_req = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            step();
            if (trigger) seen = 1'b1;
        end
        chk("man_no_early", seen, 0);
        event_qualifier = 1'b1; step(); event_qualifier = 1'b0;
        chk("man_trigger", trigger, 1);
        clear_dly(); dly[0] = 5;
        run_acq(10'h001, 0, 10'h001);
        event_qualifier = 1'b1; step(); event_qualifier = 1'b0;
        chk("man_pending_cleared", trigger, 0);

        // Request coinciding with the issuing cycle stays pending.
        manual_trig_req = 1'b1; step();
        event_qualifier = 1'b1; step();
        manual_trig_req = 1'b0; event_qualifier = 1'b0;
        chk("man_same_trigger", trigger, 1);
        clear_dly(); dly[0] = 7;
        run_acq(10'h001, 0, 10'h001);
        event_qualifier = 1'b1; step(); event_qualifier = 1'b0;
        chk("man_kept_pending", trigger, 1);
        clear_dly(); dly[0] = 3;
        run_acq(10'h001, 0, 10'h001);

        // Randomized acquisitions; en_bits changes after trigger must be ignored.
        do_reset();
        sched_src_mode = 1'b1;
        for (int t = 0; t < 10; t++) begin
            m = N'($urandom_range(1, 1023));
            any_none = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) dly[i] = -1;
                else dly[i] = $urandom_range(1, 80);
                if (m[i] && dly[i] < 0) any_none = 1'b1;
            end
            if (any_none || $urandom_range(0, 1) == 1) lim = $urandom_range(20, 90);
            else lim = 0;
            en_bits = m;
            timeout_limit = TW'(lim);
            start_manual();
            ea = N'($urandom_range(1, 1023));
            run_acq(m, lim, ea);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
